// File: rtl/method_run_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : method_run_sequencer
// Description : Drives a generated method module through a programmed number
//               of run invocations over its run_req/run_busy handshake.
//               Captures each result and keeps the last result, a wrapping
//               sum, the unsigned maximum and the busy-cycle count of the
//               most recent run.
// Revision    : 1.0 - initial release
// ============================================================================
module method_run_sequencer #(
   parameter int DATA_W      = 32,
   parameter int CNT_W       = 16,
   parameter int ACK_TIMEOUT = 8,
   parameter int RUN_TIMEOUT = 65535
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cmd_start,
   input  logic              cmd_abort,
   input  logic [CNT_W-1:0]  cmd_runs,
   output logic              seq_busy,
   output logic              seq_done,
   output logic [1:0]        seq_error,
   output logic [CNT_W-1:0]  runs_done,
   output logic [DATA_W-1:0] last_result,
   output logic [DATA_W-1:0] sum_result,
   output logic [DATA_W-1:0] max_result,
   output logic [CNT_W-1:0]  last_cycles,
   output logic              run_req,
   input  logic              run_busy,
   input  logic              finish_flag,
   input  logic [DATA_W-1:0] result_in
);

   // The acknowledge counter only has to hold 0 .. ACK_TIMEOUT-1.
   localparam int               c_ACK_W    = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
   localparam logic [c_ACK_W-1:0] c_ACK_LAST = c_ACK_W'(ACK_TIMEOUT - 1);
   localparam logic [c_ACK_W-1:0] c_ACK_ONE  = c_ACK_W'(1);
   localparam logic [CNT_W-1:0]   c_RUN_MAX  = CNT_W'(RUN_TIMEOUT);
   localparam logic [CNT_W-1:0]   c_CNT_ONE  = CNT_W'(1);

   localparam logic [1:0] c_ERR_OK    = 2'd0;
   localparam logic [1:0] c_ERR_ACK   = 2'd1;
   localparam logic [1:0] c_ERR_RUN   = 2'd2;
   localparam logic [1:0] c_ERR_ABORT = 2'd3;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_REQ     = 3'd1,
      S_WAIT    = 3'd2,
      S_CAPTURE = 3'd3,
      S_DONE    = 3'd4
   } state_t;

   state_t              r_state;
   state_t              w_next;
   logic                w_err_set;
   logic [1:0]          w_err_code;
   logic                w_accept;

   logic [CNT_W-1:0]    r_remaining;
   logic [c_ACK_W-1:0]  r_ack_cnt;
   logic [CNT_W-1:0]    r_cyc_cnt;
   logic                r_run_req;
   logic                r_seq_busy;
   logic                r_seq_done;
   logic [1:0]          r_seq_error;
   logic [CNT_W-1:0]    r_runs_done;
   logic [DATA_W-1:0]   r_last_result;
   logic [DATA_W-1:0]   r_sum_result;
   logic [DATA_W-1:0]   r_max_result;
   logic [CNT_W-1:0]    r_last_cycles;

   // A start is only honoured while idle; later pulses are dropped.
   assign w_accept = (r_state == S_IDLE) && cmd_start;

   // Next-state selection; abort outranks every other exit of REQ/WAIT/CAPTURE.
   always_comb begin
      w_next     = r_state;
      w_err_set  = 1'b0;
      w_err_code = c_ERR_OK;
      case (r_state)
         S_IDLE: begin
            if (cmd_start) begin
               w_next = (cmd_runs == '0) ? S_DONE : S_REQ;
            end
         end
         S_REQ: begin
            if (cmd_abort) begin
               w_next     = S_DONE;
               w_err_set  = 1'b1;
               w_err_code = c_ERR_ABORT;
            end else if (run_busy) begin
               w_next = S_WAIT;
            end else if (r_ack_cnt == c_ACK_LAST) begin
               w_next     = S_DONE;
               w_err_set  = 1'b1;
               w_err_code = c_ERR_ACK;
            end
         end
         S_WAIT: begin
            if (cmd_abort) begin
               w_next     = S_DONE;
               w_err_set  = 1'b1;
               w_err_code = c_ERR_ABORT;
            end else if (!run_busy || finish_flag) begin
               w_next = S_CAPTURE;
            end else if (r_cyc_cnt == c_RUN_MAX) begin
               w_next     = S_DONE;
               w_err_set  = 1'b1;
               w_err_code = c_ERR_RUN;
            end
         end
         S_CAPTURE: begin
            if (cmd_abort) begin
               w_next     = S_DONE;
               w_err_set  = 1'b1;
               w_err_code = c_ERR_ABORT;
            end else if (r_remaining == c_CNT_ONE) begin
               w_next = S_DONE;
            end else begin
               w_next = S_REQ;
            end
         end
         S_DONE: begin
            w_next = S_IDLE;
         end
         default: begin
            w_next = S_IDLE;
         end
      endcase
   end

   // Sequencer state, handshake outputs and error code, all registered from the next state.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_run_req   <= 1'b0;
         r_seq_busy  <= 1'b0;
         r_seq_done  <= 1'b0;
         r_seq_error <= c_ERR_OK;
         r_ack_cnt   <= '0;
         r_cyc_cnt   <= '0;
      end else begin
         r_state    <= w_next;
         r_run_req  <= (w_next == S_REQ);
         r_seq_busy <= (w_next != S_IDLE);
         r_seq_done <= (w_next == S_DONE);

         if (w_accept) begin
            r_seq_error <= c_ERR_OK;
         end else if (w_err_set) begin
            r_seq_error <= w_err_code;
         end

         // Every REQ visit starts counting from zero because REQ is always entered from another state.
         if (r_state != S_REQ) begin
            r_ack_cnt <= '0;
         end else if (w_next == S_REQ) begin
            r_ack_cnt <= r_ack_cnt + c_ACK_ONE;
         end

         // Busy cycles are counted only while the run stays in WAIT, so the count stops at the timeout value.
         if (r_state == S_REQ) begin
            r_cyc_cnt <= '0;
         end else if ((r_state == S_WAIT) && (w_next == S_WAIT)) begin
            r_cyc_cnt <= r_cyc_cnt + c_CNT_ONE;
         end
      end
   end

   // Result statistics: cleared on an accepted start, updated by a non-aborted CAPTURE.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_remaining   <= '0;
         r_runs_done   <= '0;
         r_last_result <= '0;
         r_sum_result  <= '0;
         r_max_result  <= '0;
         r_last_cycles <= '0;
      end else if (w_accept) begin
         r_remaining   <= cmd_runs;
         r_runs_done   <= '0;
         r_last_result <= '0;
         r_sum_result  <= '0;
         r_max_result  <= '0;
         r_last_cycles <= '0;
      end else if ((r_state == S_CAPTURE) && !cmd_abort) begin
         r_remaining   <= r_remaining - c_CNT_ONE;
         r_runs_done   <= r_runs_done + c_CNT_ONE;
         r_last_result <= result_in;
         r_sum_result  <= r_sum_result + result_in;
         r_last_cycles <= r_cyc_cnt;
         if (result_in > r_max_result) begin
            r_max_result <= result_in;
         end
      end
   end

   assign run_req     = r_run_req;
   assign seq_busy    = r_seq_busy;
   assign seq_done    = r_seq_done;
   assign seq_error   = r_seq_error;
   assign runs_done   = r_runs_done;
   assign last_result = r_last_result;
   assign sum_result  = r_sum_result;
   assign max_result  = r_max_result;
   assign last_cycles = r_last_cycles;

endmodule
`default_nettype wire
